// File: rtl/game_session_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | game_pkg: shared types and helpers for the game session controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package game_pkg;

   typedef enum logic [2:0] {
      S_HOLD  = 3'd0,
      S_IDLE  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } sess_state_t;

   localparam int SCORE_W_DEF = 32;

   function automatic int lives_w(input int lives);
      return $clog2(lives + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_session_ctrl_if.sv
// +----------------------------------------------------------------------+
// | game_session_ctrl_if: game-side inputs and session outputs bundle.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface game_session_ctrl_if #(
   parameter int LIVES   = 3,
   parameter int SCORE_W = game_pkg::SCORE_W_DEF
);
   localparam int LW = game_pkg::lives_w(LIVES);

   logic               start;
   logic               pause_bt;
   logic               tick;
   logic               collision;
   logic [SCORE_W-1:0] score;
   logic               core_rst;
   logic               run;
   logic               paused;
   logic               game_over;
   logic [LW-1:0]      lives;
   logic               hit;
   logic [SCORE_W-1:0] high_score;

   modport master (
      output start, pause_bt, tick, collision, score,
      input  core_rst, run, paused, game_over, lives, hit, high_score
   );

   modport slave (
      input  start, pause_bt, tick, collision, score,
      output core_rst, run, paused, game_over, lives, hit, high_score
   );
endinterface

`default_nettype wire

// File: rtl/game_session_ctrl_btn_rise.sv
// +----------------------------------------------------------------------+
// | btn_rise: rising-edge pulse from a level button; prev resets high.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_rise (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic btn,
   output logic      rise
);
   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = btn;
   end

   // prev resets high so a button held through reset yields no edge
   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= prev_d;
   end

   assign rise = btn & ~prev_q;
endmodule

`default_nettype wire

// File: rtl/game_session_ctrl.sv
// +----------------------------------------------------------------------+
// | game_session_ctrl: session FSM driving core_rst/run of the game,     |
// | with pause, lives, invulnerability, game-over and high score.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module game_session_ctrl
   import game_pkg::*;
#(
   parameter int RST_HOLD     = 3,
   parameter int LIVES        = 3,
   parameter int INVULN_TICKS = 4,
   parameter int SCORE_W      = SCORE_W_DEF
) (
   input wire logic           system_clk,
   input wire logic           rst,
   game_session_ctrl_if.slave bus
);
   localparam int LW = lives_w(LIVES);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int IW = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

   localparam logic [LW-1:0] C_LIVES_INIT = LW'(LIVES);
   localparam logic [LW-1:0] C_ONE_LIFE   = LW'(1);
   localparam logic [HW-1:0] C_HOLD_LAST  = HW'(RST_HOLD);
   localparam logic [IW-1:0] C_INV_INIT   = IW'(INVULN_TICKS);

   logic start_rise;
   logic pause_rise;

   btn_rise u_start_rise (.clk(system_clk), .rst(rst), .btn(bus.start),    .rise(start_rise));
   btn_rise u_pause_rise (.clk(system_clk), .rst(rst), .btn(bus.pause_bt), .rise(pause_rise));

   sess_state_t        state_q,      state_d;
   logic [HW-1:0]      hold_cnt_q,   hold_cnt_d;
   logic [IW-1:0]      invuln_q,     invuln_d;
   logic [LW-1:0]      lives_q,      lives_d;
   logic [SCORE_W-1:0] high_score_q, high_score_d;
   logic               core_rst_q,   core_rst_d;
   logic               run_q,        run_d;
   logic               paused_q,     paused_d;
   logic               game_over_q,  game_over_d;
   logic               hit_q,        hit_d;
   logic               over_entry_q, over_entry_d;

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      invuln_d     = invuln_q;
      lives_d      = lives_q;
      high_score_d = high_score_q;
      core_rst_d   = core_rst_q;
      run_d        = run_q;
      paused_d     = paused_q;
      game_over_d  = game_over_q;
      hit_d        = 1'b0;
      over_entry_d = 1'b0;

      case (state_q)
         S_HOLD: begin
            core_rst_d = 1'b1;
            if (hold_cnt_q == C_HOLD_LAST) state_d = S_IDLE;
            else                           hold_cnt_d = hold_cnt_q + 1'b1;
         end
         S_IDLE: begin
            core_rst_d = 1'b1;
            lives_d    = C_LIVES_INIT;
            if (start_rise) begin
               state_d    = S_RUN;
               core_rst_d = 1'b0;
               run_d      = 1'b1;
               invuln_d   = '0;
            end
         end
         S_RUN: begin
            // collision is resolved before a same-cycle pause edge
            if (bus.collision && invuln_q == '0) begin
               lives_d  = lives_q - 1'b1;
               hit_d    = 1'b1;
               invuln_d = C_INV_INIT;
               if (lives_q == C_ONE_LIFE) begin
                  state_d      = S_OVER;
                  run_d        = 1'b0;
                  game_over_d  = 1'b1;
                  over_entry_d = 1'b1;
               end
            end else if (bus.tick && invuln_q != '0) begin
               invuln_d = invuln_q - 1'b1;
            end
            if (state_d == S_RUN && pause_rise) begin
               state_d  = S_PAUSE;
               run_d    = 1'b0;
               paused_d = 1'b1;
            end
         end
         S_PAUSE: begin
            if (pause_rise) begin
               state_d  = S_RUN;
               run_d    = 1'b1;
               paused_d = 1'b0;
            end
         end
         S_OVER: begin
            if (over_entry_q && bus.score > high_score_q) high_score_d = bus.score;
            if (start_rise) begin
               state_d     = S_HOLD;
               hold_cnt_d  = '0;
               core_rst_d  = 1'b1;
               game_over_d = 1'b0;
               lives_d     = C_LIVES_INIT;
               invuln_d    = '0;
            end
         end
         default: begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            core_rst_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_q      <= S_HOLD;
         hold_cnt_q   <= '0;
         invuln_q     <= '0;
         lives_q      <= C_LIVES_INIT;
         high_score_q <= '0;
         core_rst_q   <= 1'b1;
         run_q        <= 1'b0;
         paused_q     <= 1'b0;
         game_over_q  <= 1'b0;
         hit_q        <= 1'b0;
         over_entry_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         invuln_q     <= invuln_d;
         lives_q      <= lives_d;
         high_score_q <= high_score_d;
         core_rst_q   <= core_rst_d;
         run_q        <= run_d;
         paused_q     <= paused_d;
         game_over_q  <= game_over_d;
         hit_q        <= hit_d;
         over_entry_q <= over_entry_d;
      end
   end

   assign bus.core_rst   = core_rst_q;
   assign bus.run        = run_q;
   assign bus.paused     = paused_q;
   assign bus.game_over  = game_over_q;
   assign bus.lives      = lives_q;
   assign bus.hit        = hit_q;
   assign bus.high_score = high_score_q;
endmodule

`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_game_session_ctrl: directed self-checking bench for the session   |
// | controller. Revision: 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_game_session_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   hits;

   always #5 clk = ~clk;

   game_session_ctrl_if #(.LIVES(3), .SCORE_W(32)) bus ();

   game_session_ctrl #(
      .RST_HOLD(3), .LIVES(3), .INVULN_TICKS(2), .SCORE_W(32)
   ) dut (
      .system_clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_core_rst"},  64'(bus.core_rst),   64'd1);
      check_val({tag, "_run"},       64'(bus.run),        64'd0);
      check_val({tag, "_paused"},    64'(bus.paused),     64'd0);
      check_val({tag, "_game_over"}, 64'(bus.game_over),  64'd0);
      check_val({tag, "_lives"},     64'(bus.lives),      64'd3);
      check_val({tag, "_hit"},       64'(bus.hit),        64'd0);
      check_val({tag, "_high"},      64'(bus.high_score), 64'd0);
   endtask

   initial begin
      bus.start = 1'b1; bus.pause_bt = 1'b0; bus.tick = 1'b0;
      bus.collision = 1'b0; bus.score = '0;

      // start held through reset must not launch a session
      rst = 1'b1; cyc();
      check_reset_outputs("rst0");
      rst = 1'b0; cyc(8);
      check_val("held_start_run", 64'(bus.run),      64'd0);
      check_val("held_start_crst", 64'(bus.core_rst), 64'd1);

      // reset again, probe HOLD->IDLE boundary
      bus.start = 1'b0;
      rst = 1'b1; cyc();
      rst = 1'b0; cyc(3);
      check_val("hold_crst", 64'(bus.core_rst), 64'd1);
      bus.start = 1'b1; cyc();
      check_val("hold_edge_ignored", 64'(bus.run), 64'd0);
      bus.start = 1'b0; cyc();
      bus.start = 1'b1; cyc();
      check_val("start_run",  64'(bus.run),      64'd1);
      check_val("start_crst", 64'(bus.core_rst), 64'd0);
      bus.start = 1'b0;

      // sustained collision with no tick: one hit only
      hits = 0;
      bus.collision = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (bus.hit) hits++;
      end
      bus.collision = 1'b0;
      check_val("invuln_hits", 64'(hits),      64'd1);
      check_val("invuln_lives", 64'(bus.lives), 64'd2);

      bus.tick = 1'b1; cyc(2); bus.tick = 1'b0;
      bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
      check_val("hit2_lives", 64'(bus.lives), 64'd1);
      check_val("hit2_pulse", 64'(bus.hit),   64'd1);
      cyc();
      check_val("hit2_pulse_end", 64'(bus.hit), 64'd0);

      // pause freezes lives and invuln
      bus.pause_bt = 1'b1; cyc(); bus.pause_bt = 1'b0;
      check_val("pause_paused", 64'(bus.paused), 64'd1);
      check_val("pause_run",    64'(bus.run),    64'd0);
      for (int i = 0; i < 20; i++) begin
         bus.collision = 1'b1; bus.tick = i[0]; cyc();
      end
      bus.collision = 1'b0; bus.tick = 1'b0;
      check_val("pause_lives", 64'(bus.lives), 64'd1);
      bus.pause_bt = 1'b1; cyc(); bus.pause_bt = 1'b0;
      check_val("resume_run",    64'(bus.run),    64'd1);
      check_val("resume_paused", 64'(bus.paused), 64'd0);

      // invuln still 2 after pause; clear it then take fatal hit
      bus.tick = 1'b1; cyc(2); bus.tick = 1'b0;
      bus.score = 32'd57;
      bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
      check_val("over_flag",  64'(bus.game_over), 64'd1);
      check_val("over_run",   64'(bus.run),       64'd0);
      check_val("over_lives", 64'(bus.lives),     64'd0);
      check_val("over_crst",  64'(bus.core_rst),  64'd0);
      cyc();
      check_val("over_high", 64'(bus.high_score), 64'd57);

      // restart keeps high score
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      check_val("restart_crst",  64'(bus.core_rst),  64'd1);
      check_val("restart_over",  64'(bus.game_over), 64'd0);
      check_val("restart_lives", 64'(bus.lives),     64'd3);
      cyc(5);
      bus.start = 1'b1; cyc(); bus.start = 1'b0;
      check_val("restart_run", 64'(bus.run), 64'd1);

      // non-fatal collision together with pause edge
      bus.collision = 1'b1; bus.pause_bt = 1'b1; cyc();
      bus.collision = 1'b0; bus.pause_bt = 1'b0;
      check_val("simul_paused", 64'(bus.paused), 64'd1);
      check_val("simul_lives",  64'(bus.lives),  64'd2);
      check_val("simul_hit",    64'(bus.hit),    64'd1);
      cyc();
      bus.pause_bt = 1'b1; cyc(); bus.pause_bt = 1'b0;
      check_val("simul_resume", 64'(bus.run), 64'd1);
      cyc();

      // pause and start edges together: pause only
      bus.pause_bt = 1'b1; bus.start = 1'b1; cyc();
      bus.pause_bt = 1'b0; bus.start = 1'b0;
      check_val("ps_paused", 64'(bus.paused),   64'd1);
      check_val("ps_crst",   64'(bus.core_rst), 64'd0);
      cyc();
      bus.pause_bt = 1'b1; cyc(); bus.pause_bt = 1'b0;
      check_val("ps_resume", 64'(bus.run), 64'd1);

      // finish second session at a lower score
      bus.tick = 1'b1; cyc(2); bus.tick = 1'b0;
      bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
      check_val("s2_lives", 64'(bus.lives), 64'd1);
      bus.tick = 1'b1; cyc(2); bus.tick = 1'b0;
      bus.score = 32'd40;
      bus.collision = 1'b1; cyc(); bus.collision = 1'b0;
      check_val("s2_over", 64'(bus.game_over), 64'd1);
      cyc();
      check_val("s2_high_kept", 64'(bus.high_score), 64'd57);

      // mid-operation reset clears everything
      rst = 1'b1; cyc(); rst = 1'b0;
      check_reset_outputs("rst_over");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
